// File: rtl/decoder_index_sequencer.sv
// Switch/pushbutton front end for the 4x16 LED decoder: manual, step and run (wrap or ping-pong) index modes.
// Build option: define DEBOUNCE_EN for the full DB_CYCLES button debounce; otherwise the synced button is used directly.
module decoder_index_sequencer #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] SW,
  input  logic        BTN_STEP,
  output logic [15:0] dec_sw,
  output logic [3:0]  idx,
  output logic        wrap
);

  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {ST_OFF, ST_MANUAL, ST_STEP, ST_RUN} state_t;

  logic [15:0] sw_s1_q, sw_s2_q;
  logic        btn_s1_q, btn_s2_q;

  // NOTE: clocked blocks use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
    end else begin
      sw_s1_q  <= SW;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= BTN_STEP;
      btn_s2_q <= btn_s1_q;
    end
  end

  logic db_level;
  logic unused_ok;

`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES);

  logic [DW-1:0] db_cnt_q;
  logic          db_q;

  // The level flips only after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q <= '0;
      db_q     <= 1'b0;
    end else if (btn_s2_q == db_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DW'(DB_CYCLES - 1)) begin
      db_cnt_q <= '0;
      db_q     <= ~db_q;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign db_level  = db_q;
  assign unused_ok = ^sw_s2_q[14:8];
`else
  assign db_level  = btn_s2_q;
  assign unused_ok = ^{sw_s2_q[14:8], (DB_CYCLES < 2)};
`endif

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic           dir_q, dir_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           wrap_q, wrap_d;
  logic           db_prev_q;

  logic           db_rise;
  logic           run_entry;
  logic           advance;
  logic           dir_cur;
  logic           pingpong;

  assign db_rise   = db_level & ~db_prev_q;
  assign run_entry = (state_q != ST_RUN);

  always_comb begin
    state_d = ST_OFF;
    if (!sw_s2_q[15])    state_d = ST_OFF;
    else if (sw_s2_q[4]) state_d = ST_RUN;
    else if (sw_s2_q[5]) state_d = ST_STEP;
    else                 state_d = ST_MANUAL;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    idx_d    = idx_q;
    dir_d    = dir_q;
    presc_d  = presc_q;
    wrap_d   = 1'b0;
    advance  = 1'b0;
    dir_cur  = sw_s2_q[6];
    pingpong = 1'b0;

    unique case (state_d)
      ST_OFF:    ;
      ST_MANUAL: idx_d = sw_s2_q[3:0];
      ST_STEP:   advance = db_rise;
      ST_RUN: begin
        pingpong = sw_s2_q[7];
        // Once running in ping-pong, the block owns the direction.
        if (pingpong && !run_entry) dir_cur = dir_q;
        if (run_entry) begin
          presc_d = '0;
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          advance = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default:   ;
    endcase

    if (state_d != ST_OFF) dir_d = dir_cur;

    if (advance) begin
      if (!dir_cur && idx_q == 4'd15) begin
        wrap_d = 1'b1;
        if (pingpong) begin
          dir_d = 1'b1;
          idx_d = 4'd14;
        end else begin
          idx_d = 4'd0;
        end
      end else if (dir_cur && idx_q == 4'd0) begin
        wrap_d = 1'b1;
        if (pingpong) begin
          dir_d = 1'b0;
          idx_d = 4'd1;
        end else begin
          idx_d = 4'd15;
        end
      end else begin
        idx_d = dir_cur ? idx_q - 1'b1 : idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OFF;
      idx_q     <= 4'd0;
      dir_q     <= 1'b0;
      presc_q   <= '0;
      wrap_q    <= 1'b0;
      db_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dir_q     <= dir_d;
      presc_q   <= presc_d;
      wrap_q    <= wrap_d;
      db_prev_q <= db_level;
    end
  end

  assign dec_sw = (state_q == ST_OFF) ? 16'h0000 : {1'b1, 11'b0, idx_q};
  assign idx    = idx_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_decoder_index_sequencer.sv
// Bench for decoder_index_sequencer: directed vector tables, hand-written press sequences,
// and randomized switch/button activity checked every cycle against a behavioural model.
module tb_decoder_index_sequencer;

  localparam int TICK_DIV  = 4;
  localparam int DB_CYCLES = 8;
`ifdef DEBOUNCE_EN
  localparam bit USE_DB = 1'b1;
`else
  localparam bit USE_DB = 1'b0;
`endif
  // Press to index update: 2 sync cycles, optional debounce window, 1 edge-detect cycle.
  localparam int         PRESS_LAT  = USE_DB ? DB_CYCLES + 3 : 3;
  // Without debounce each of the three bounce highs is a separate press.
  localparam logic [3:0] BOUNCE_IDX = USE_DB ? 4'd6 : 4'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] SW;
  logic        BTN_STEP;
  logic [15:0] dec_sw;
  logic [3:0]  idx;
  logic        wrap;

  always #5 clk = ~clk;

  decoder_index_sequencer #(
    .TICK_DIV (TICK_DIV),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .SW      (SW),
    .BTN_STEP(BTN_STEP),
    .dec_sw  (dec_sw),
    .idx     (idx),
    .wrap    (wrap)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: switch/button delay lines, mode decided from the delayed switches,
  // run steps counted as multiples of TICK_DIV since RUN was entered.
  logic [15:0] m_sw1, m_sw2;
  bit          m_btn1, m_btn2;
  int          m_idx;
  bit          m_dir, m_en, m_wrap;
  int          m_run_age;
  bit          m_db, m_db_prev;
  int          m_db_mis;

  task automatic model_move(input bit down, input bit pp);
    int nxt;
    nxt = down ? m_idx - 1 : m_idx + 1;
    if (nxt < 0 || nxt > 15) begin
      m_wrap = 1'b1;
      if (pp) begin
        m_dir = ~down;
        m_idx = down ? 1 : 14;
      end else begin
        m_idx = (nxt + 16) % 16;
      end
    end else begin
      m_idx = nxt;
    end
  endtask

  task automatic model_clock();
    logic [15:0] s;
    bit b, lvl, rise;
    s = m_sw2;
    b = m_btn2;
    if (rst) begin
      m_sw1 = '0; m_sw2 = '0; m_btn1 = 1'b0; m_btn2 = 1'b0;
      m_idx = 0; m_en = 1'b0; m_wrap = 1'b0; m_dir = 1'b0; m_run_age = -1;
      m_db = 1'b0; m_db_mis = 0; m_db_prev = 1'b0;
      return;
    end
    lvl = USE_DB ? m_db : b;
    rise = lvl && !m_db_prev;
    m_db_prev = lvl;
    if (USE_DB) begin
      if (b == m_db) m_db_mis = 0;
      else begin
        m_db_mis++;
        if (m_db_mis == DB_CYCLES) begin
          m_db = ~m_db;
          m_db_mis = 0;
        end
      end
    end
    m_wrap = 1'b0;
    if (!s[15]) begin
      m_en = 1'b0;
      m_run_age = -1;
    end else if (s[4]) begin
      m_en = 1'b1;
      m_run_age = (m_run_age < 0) ? 0 : m_run_age + 1;
      if (!(s[7] && m_run_age > 0)) m_dir = s[6];
      if (m_run_age > 0 && m_run_age % TICK_DIV == 0) model_move(m_dir, s[7]);
    end else begin
      m_en = 1'b1;
      m_run_age = -1;
      m_dir = s[6];
      if (s[5]) begin
        if (rise) model_move(s[6], 1'b0);
      end else begin
        m_idx = int'(s[3:0]);
      end
    end
    m_sw2 = m_sw1; m_sw1 = SW;
    m_btn2 = m_btn1; m_btn1 = BTN_STEP;
  endtask

  task automatic step_clk();
    @(posedge clk);
    model_clock();
    #1;
    check("model_idx", {12'b0, idx}, {12'b0, 4'(m_idx)});
    check("model_dec_sw", dec_sw, m_en ? (16'h8000 | 16'(m_idx)) : 16'h0000);
    check("model_wrap", {15'b0, wrap}, {15'b0, m_wrap});
  endtask

  typedef struct {
    bit          rst;
    logic [15:0] sw;
    bit          btn;
    int          cycles;
    logic [3:0]  idx;
    logic [15:0] dec;
    bit          wrap;
    string       name;
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];

  task automatic add(input bit b_tab, input bit r, input logic [15:0] sw, input bit btn,
                     input int cyc, input logic [3:0] ix, input logic [15:0] dec,
                     input bit wr, input string name);
    vec_t v;
    v.rst = r; v.sw = sw; v.btn = btn; v.cycles = cyc;
    v.idx = ix; v.dec = dec; v.wrap = wr; v.name = name;
    if (b_tab) tab_b.push_back(v);
    else       tab_a.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    rst = v.rst; SW = v.sw; BTN_STEP = v.btn;
    repeat (v.cycles) step_clk();
    check({v.name, "_idx"},    {12'b0, idx},  {12'b0, v.idx});
    check({v.name, "_dec_sw"}, dec_sw,        v.dec);
    check({v.name, "_wrap"},   {15'b0, wrap}, {15'b0, v.wrap});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  seen;
    logic [15:0] r;
    int  hold;

    rst = 1'b1; SW = 16'h0000; BTN_STEP = 1'b0;

    //   tab rst  sw        btn cyc idx    dec_sw    wrap name
    add(0, 1, 16'h0000, 0,  2,  4'd0,  16'h0000, 0, "reset");
    add(0, 0, 16'h8005, 0,  2,  4'd0,  16'h0000, 0, "sw_latency_2");
    add(0, 0, 16'h8005, 0,  1,  4'd5,  16'h8005, 0, "manual_5");
    add(0, 0, 16'h0005, 0,  3,  4'd5,  16'h0000, 0, "off_hold");
    add(0, 0, 16'h0005, 1, 12,  4'd5,  16'h0000, 0, "off_btn_high");
    add(0, 0, 16'h0005, 0, 12,  4'd5,  16'h0000, 0, "off_btn_low");
    add(0, 0, 16'h8020, 0,  3,  4'd5,  16'h8005, 0, "step_idle");

    add(1, 0, 16'h8001, 0,  3,  4'd1,  16'h8001, 0, "manual_1");
    add(1, 0, 16'h8050, 0,  6,  4'd1,  16'h8001, 0, "run_entry_hold");
    add(1, 0, 16'h8050, 0,  1,  4'd0,  16'h8000, 0, "run_down_first");
    add(1, 0, 16'h8050, 0,  3,  4'd0,  16'h8000, 0, "run_period");
    add(1, 0, 16'h8050, 0,  1,  4'd15, 16'h800F, 1, "run_wrap_down");
    add(1, 0, 16'h8050, 0,  1,  4'd15, 16'h800F, 0, "run_wrap_end");
    add(1, 0, 16'h8050, 0,  3,  4'd14, 16'h800E, 0, "run_next");
    add(1, 0, 16'h800E, 0,  3,  4'd14, 16'h800E, 0, "manual_14");
    add(1, 0, 16'h8090, 0,  7,  4'd15, 16'h800F, 0, "pp_up_15");
    add(1, 0, 16'h8090, 0,  3,  4'd15, 16'h800F, 0, "pp_hold");
    add(1, 0, 16'h8090, 0,  1,  4'd14, 16'h800E, 1, "pp_turn");
    add(1, 0, 16'h8090, 0,  4,  4'd13, 16'h800D, 0, "pp_down");
    add(1, 0, 16'h8090, 0,  4,  4'd12, 16'h800C, 0, "pp_continue");
    add(1, 0, 16'h8009, 0,  3,  4'd9,  16'h8009, 0, "manual_9");
    add(1, 0, 16'h8050, 0,  5,  4'd9,  16'h8009, 0, "run_at_9");
    add(1, 1, 16'h8050, 0,  1,  4'd0,  16'h0000, 0, "rst_mid_run");
    add(1, 0, 16'h8050, 0,  6,  4'd0,  16'h8000, 0, "rerun_entry_hold");
    add(1, 0, 16'h8050, 0,  1,  4'd15, 16'h800F, 1, "rerun_first_step");

    foreach (tab_a[i]) run_vec(tab_a[i]);

    // Bouncy press in step mode: five one-cycle bounces, then a solid hold.
    SW = 16'h8020;
    for (int k = 0; k < 5; k++) begin
      BTN_STEP = (k % 2 == 0);
      step_clk();
    end
    BTN_STEP = 1'b1;
    repeat (12) step_clk();
    check("bounce_idx", {12'b0, idx}, {12'b0, BOUNCE_IDX});
    check("bounce_dec_sw", dec_sw, {1'b1, 11'b0, BOUNCE_IDX});
    BTN_STEP = 1'b0;
    repeat (14) step_clk();
    check("bounce_release_idx", {12'b0, idx}, {12'b0, BOUNCE_IDX});

    // Clean press from 15 going up: exact latency, wrap to 0, single-cycle pulse.
    SW = 16'h800F;
    repeat (3) step_clk();
    SW = 16'h8020;
    repeat (3) step_clk();
    check("press_start_idx", {12'b0, idx}, 16'd15);
    BTN_STEP = 1'b1;
    lat = 0;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      step_clk();
      if (wrap === 1'b1) begin
        seen = 1'b1;
        lat = c;
      end
    end
    check("press_wrap_seen", {15'b0, seen}, 16'd1);
    check("press_latency", 16'(lat), 16'(PRESS_LAT));
    check("press_wrap_idx", {12'b0, idx}, 16'd0);
    step_clk();
    check("press_wrap_width", {15'b0, wrap}, 16'd0);
    BTN_STEP = 1'b0;
    repeat (14) step_clk();
    check("press_release_idx", {12'b0, idx}, 16'd0);

    foreach (tab_b[i]) run_vec(tab_b[i]);

    // Randomized switch settings and button activity, checked every cycle by the model.
    for (int seg = 0; seg < 160; seg++) begin
      r = 16'($urandom);
      r[15] = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 40) == 0);
      SW = r;
      BTN_STEP = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 30);
      for (int c = 0; c < hold; c++) begin
        if ($urandom_range(0, 9) == 0) BTN_STEP = ~BTN_STEP;
        step_clk();
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
